// File: rtl/ika87ad_opfetch_if.sv
// Opcode fetch bus bundle: bus-unit byte handshake plus the {page, opcode} handoff to the microsequencer.
// The master modport is the opcode fetch sequencer; the slave modport is its environment.
interface ika87ad_opfetch_if;
    logic       fetch_req;
    logic       fetch_ack;
    logic [7:0] data;
    logic       pc_inc;
    logic [7:0] opcode;
    logic [2:0] opcode_page;
    logic       op_valid;
    logic       op_int;
    logic       op_taken;
    logic       flush;
    logic       irq;

    modport master (
        output fetch_req, pc_inc, opcode, opcode_page, op_valid, op_int,
        input  fetch_ack, data, op_taken, flush, irq
    );

    modport slave (
        input  fetch_req, pc_inc, opcode, opcode_page, op_valid, op_int,
        output fetch_ack, data, op_taken, flush, irq
    );
endinterface

// File: rtl/ika87ad_opfetch.sv
// IKA87AD opcode fetch sequencer: resolves uPD7810 prefixes into a page and presents {page, opcode}.
// Define IKA87AD_OPFETCH_HARDI_EN to inject the interrupt pseudo-opcode 0x73 at instruction boundaries.
//
// state | meaning
// IDLE  | post-reset, one cycle before the first fetch
// F1    | fetching the first byte (opcode or prefix)
// F2    | fetching the opcode byte that follows a prefix
// HOLD  | {page, opcode} presented, waiting for taken
module ika87ad_opfetch (
    input  logic                   i_EMUCLK,
    input  logic                   i_RST,
    ika87ad_opfetch_if.master      bus
);

    typedef enum logic [1:0] {IDLE, F1, F2, HOLD} state_t;

    state_t     state;
    logic [2:0] page_lat;
    logic       fetch_req_q;
    logic [7:0] opcode_q;
    logic [2:0] page_q;
    logic       valid_q;
    logic       int_q;

    logic       is_prefix;
    logic [2:0] prefix_page;
    logic       inject;

    // 0x4C/0x4D are deliberately absent: they are page-0 opcodes with a microcode-fetched operand.
    always_comb begin
        is_prefix   = 1'b1;
        prefix_page = 3'd0;
        case (bus.data)
            8'h48:   prefix_page = 3'd1;
            8'h60:   prefix_page = 3'd2;
            8'h64:   prefix_page = 3'd3;
            8'h70:   prefix_page = 3'd4;
            8'h74:   prefix_page = 3'd5;
            default: is_prefix   = 1'b0;
        endcase
    end

`ifdef IKA87AD_OPFETCH_HARDI_EN
    assign inject = bus.irq;
`else
    logic unused_irq;
    assign unused_irq = bus.irq;
    assign inject     = 1'b0;
`endif

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state       <= IDLE;
            page_lat    <= 3'd0;
            fetch_req_q <= 1'b0;
            opcode_q    <= 8'h00;
            page_q      <= 3'd0;
            valid_q     <= 1'b0;
            int_q       <= 1'b0;
        end else if (bus.flush) begin
            state       <= F1;
            page_lat    <= 3'd0;
            fetch_req_q <= 1'b1;
            valid_q     <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= F1;
                    fetch_req_q <= 1'b1;
                end
                F1: begin
                    if (bus.fetch_ack) begin
                        if (is_prefix) begin
                            page_lat <= prefix_page;
                            state    <= F2;
                        end else begin
                            opcode_q    <= bus.data;
                            page_q      <= 3'd0;
                            valid_q     <= 1'b1;
                            fetch_req_q <= 1'b0;
                            state       <= HOLD;
                        end
                    end
                end
                F2: begin
                    // No prefix chaining: any byte here is an opcode of the latched page.
                    if (bus.fetch_ack) begin
                        opcode_q    <= bus.data;
                        page_q      <= page_lat;
                        valid_q     <= 1'b1;
                        fetch_req_q <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.op_taken) begin
                        if (inject) begin
                            opcode_q <= 8'h73;
                            page_q   <= 3'd0;
                            int_q    <= 1'b1;
                        end else begin
                            valid_q     <= 1'b0;
                            int_q       <= 1'b0;
                            fetch_req_q <= 1'b1;
                            state       <= F1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_req_q <= 1'b0;
                    valid_q     <= 1'b0;
                    int_q       <= 1'b0;
                end
            endcase
        end
    end

    // A flushed byte is never consumed, so the PC must not advance for it.
    assign bus.pc_inc      = fetch_req_q & bus.fetch_ack & ~bus.flush;
    assign bus.fetch_req   = fetch_req_q;
    assign bus.opcode      = opcode_q;
    assign bus.opcode_page = page_q;
    assign bus.op_valid    = valid_q;
    assign bus.op_int      = int_q;

endmodule
